// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I-subset control FSM with memory-ready handshake
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic       done_raw, illegal_raw;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        done_raw      = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_raw = 1'b0;
                    default: begin
                        illegal_raw = 1'b1;
                        done_raw    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA      = 2'b10;
                alu_op       = 2'b01;
                pc_write_raw = Zero;
                done_raw     = 1'b1;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link value
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b110;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Write-type strobes are held off for the whole time reset is high
    assign PCWrite    = pc_write_raw  & ~reset;
    assign MemWrite   = mem_write_raw & ~reset;
    assign IRWrite    = ir_write_raw  & ~reset;
    assign RegWrite   = reg_write_raw & ~reset;
    assign instr_done = done_raw      & ~reset;
    assign illegal    = illegal_raw   & ~reset;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed-vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    wire [15:0] outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                        ALUSrcA, ALUSrcB, ALUControl, instr_done, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, done, ill};
    endfunction

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, input logic mr);
        op = o; funct3 = f3; funct7 = f7; Zero = z; mem_ready = mr;
    endtask

    // Check state and output bundle mid-cycle, then advance to just after the next edge
    task automatic step(input string tag, input logic [3:0] es, input logic [15:0] ev);
        #1;
        check({tag, ".state"}, {28'd0, state}, {28'd0, es});
        check({tag, ".outs"}, {16'd0, outs}, {16'd0, ev});
        @(posedge clk);
        #1;
    endtask

    logic [15:0] v_fetch, v_decode, v_memadr, v_aluwb;

    initial begin
        v_fetch  = ov(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
        v_decode = ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
        v_memadr = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
        v_aluwb  = ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);

        repeat (2) @(posedge clk);
        #2;
        check("rst.state", {28'd0, state}, 32'd0);
        check("rst.outs", {16'd0, outs}, {16'd0, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0)});
        check("rst.imm", {30'd0, ImmSrc}, 32'd0);
        reset = 1'b0;

        // lw, no waits, then one wait cycle in MEMREAD on a second lw
        set_in(7'b0000011, 3'b010, 0, 0, 1);
        step("lw.fetch", 4'd0, v_fetch);
        step("lw.decode", 4'd1, v_decode);
        step("lw.memadr", 4'd2, v_memadr);
        step("lw.memread", 4'd3, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("lw.memwb", 4'd4, ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));
        mem_ready = 1'b0;
        step("fwait", 4'd0, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0));
        mem_ready = 1'b1;
        step("lw2.fetch", 4'd0, v_fetch);
        step("lw2.decode", 4'd1, v_decode);
        step("lw2.memadr", 4'd2, v_memadr);
        mem_ready = 1'b0;
        step("lw2.mrwait", 4'd3, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        mem_ready = 1'b1;
        step("lw2.memread", 4'd3, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("lw2.memwb", 4'd4, ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));

        // sw with two wait cycles in MEMWRITE
        set_in(7'b0100011, 3'b010, 0, 0, 1);
        step("sw.fetch", 4'd0, v_fetch);
        step("sw.decode", 4'd1, v_decode);
        #1 check("sw.imm", {30'd0, ImmSrc}, 32'd1);
        step("sw.memadr", 4'd2, v_memadr);
        mem_ready = 1'b0;
        step("sw.w1", 4'd5, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("sw.w2", 4'd5, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        mem_ready = 1'b1;
        step("sw.done", 4'd5, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        // R/I-type ALU decode
        set_in(7'b0110011, 3'b000, 1, 0, 1);
        step("sub.fetch", 4'd0, v_fetch);
        step("sub.decode", 4'd1, v_decode);
        step("sub.execr", 4'd6, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0));
        step("sub.aluwb", 4'd8, v_aluwb);
        set_in(7'b0010011, 3'b000, 1, 0, 1);
        step("addi.fetch", 4'd0, v_fetch);
        step("addi.decode", 4'd1, v_decode);
        step("addi.execi", 4'd7, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
        step("addi.aluwb", 4'd8, v_aluwb);
        set_in(7'b0110011, 3'b111, 0, 0, 1);
        step("and.fetch", 4'd0, v_fetch);
        step("and.decode", 4'd1, v_decode);
        step("and.execr", 4'd6, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0, 0));
        step("and.aluwb", 4'd8, v_aluwb);
        set_in(7'b0110011, 3'b110, 0, 0, 1);
        step("or.fetch", 4'd0, v_fetch);
        step("or.decode", 4'd1, v_decode);
        step("or.execr", 4'd6, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b110, 0, 0));
        step("or.aluwb", 4'd8, v_aluwb);
        set_in(7'b0010011, 3'b010, 0, 0, 1);
        step("slti.fetch", 4'd0, v_fetch);
        step("slti.decode", 4'd1, v_decode);
        step("slti.execi", 4'd7, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 0, 0));
        step("slti.aluwb", 4'd8, v_aluwb);
        set_in(7'b0110011, 3'b001, 0, 0, 1);
        step("sll.fetch", 4'd0, v_fetch);
        step("sll.decode", 4'd1, v_decode);
        step("sll.execr", 4'd6, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
        step("sll.aluwb", 4'd8, v_aluwb);

        // beq taken and not taken
        set_in(7'b1100011, 3'b000, 0, 1, 1);
        step("beqt.fetch", 4'd0, v_fetch);
        #1 check("beq.imm", {30'd0, ImmSrc}, 32'd2);
        step("beqt.decode", 4'd1, v_decode);
        step("beqt.beq", 4'd9, ov(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));
        Zero = 1'b0;
        step("beqn.fetch", 4'd0, v_fetch);
        step("beqn.decode", 4'd1, v_decode);
        step("beqn.beq", 4'd9, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));

        // jal
        set_in(7'b1101111, 3'b000, 0, 0, 1);
        step("jal.fetch", 4'd0, v_fetch);
        #1 check("jal.imm", {30'd0, ImmSrc}, 32'd3);
        step("jal.decode", 4'd1, v_decode);
        step("jal.jal", 4'd10, ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
        step("jal.aluwb", 4'd8, v_aluwb);

        // unsupported opcode (lui)
        set_in(7'b0110111, 3'b000, 0, 0, 1);
        step("ill.fetch", 4'd0, v_fetch);
        step("ill.decode", 4'd1, ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1, 1));

        // reset while MEMWRITE is waiting
        set_in(7'b0100011, 3'b010, 0, 0, 1);
        step("rsw.fetch", 4'd0, v_fetch);
        step("rsw.decode", 4'd1, v_decode);
        step("rsw.memadr", 4'd2, v_memadr);
        mem_ready = 1'b0;
        #1 check("rsw.mw", {31'd0, MemWrite}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rsw.rst_mw", {31'd0, MemWrite}, 32'd0);
        check("rsw.rst_state", {28'd0, state}, 32'd0);
        check("rsw.rst_outs", {16'd0, outs}, {16'd0, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0)});
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        step("rsw.fetch2", 4'd0, v_fetch);
        step("rsw.decode2", 4'd1, v_decode);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
